axis_uart_bridge_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single transmit path of the AXI-Stream UART bridge between N_CHANNELS independent AXI-Stream requesters. Each grant lasts one burst, which ends on an input TLAST or after MAX_BURST words. Every output word is tagged with its source channel on TDEST and passes through one output register. The block sits directly in front of the bridge's S_AXIS port.

---
 rtl/axis_uart_bridge_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_axis_uart_bridge_tx_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_bridge_tx_arbiter.sv
// Round-robin arbiter sharing the UART bridge transmit stream between N_CHANNELS
// AXI-Stream requesters; one burst per grant, tagged with the source on TDEST.
module axis_uart_bridge_tx_arbiter #(
    parameter int N_BYTES    = 32,
    parameter int N_CHANNELS = 4,
    parameter int MAX_BURST  = 8,
    localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int CNT_W = $clog2(MAX_BURST + 1),
    localparam int DW    = N_BYTES * 8
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic [N_CHANNELS*DW-1:0] S_AXIS_TDATA,
    input  logic [N_CHANNELS-1:0]    S_AXIS_TVALID,
    input  logic [N_CHANNELS-1:0]    S_AXIS_TLAST,
    output logic [N_CHANNELS-1:0]    S_AXIS_TREADY,
    output logic [DW-1:0]            M_AXIS_TDATA,
    output logic [CH_W-1:0]          M_AXIS_TDEST,
    output logic                     M_AXIS_TLAST,
    output logic                     M_AXIS_TVALID,
    input  logic                     M_AXIS_TREADY
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CH_W-1:0] gnt_q, gnt_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DW-1:0]   tdata_q;
    logic [CH_W-1:0] tdest_q;
    logic            tlast_q;
    logic            tvalid_q;

    logic [CH_W-1:0] pick;
    logic            out_free;
    logic            gnt_valid;
    logic            accept;
    logic            beat_last;

    // Walk downward so the channel closest to ptr (lowest offset) wins.
    always_comb begin
        pick = ptr_q;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            int idx;
            idx = int'(ptr_q) + i;
            if (idx >= N_CHANNELS) idx = idx - N_CHANNELS;
            if (S_AXIS_TVALID[idx]) pick = CH_W'(idx);
        end
    end

    assign out_free  = !tvalid_q || M_AXIS_TREADY;
    assign gnt_valid = S_AXIS_TVALID[gnt_q];
    assign accept    = (state_q == S_GRANT) && gnt_valid && out_free;
    assign beat_last = S_AXIS_TLAST[gnt_q] || (cnt_q == CNT_W'(MAX_BURST - 1));

    always_comb begin
        S_AXIS_TREADY = '0;
        if (state_q == S_GRANT) S_AXIS_TREADY[gnt_q] = out_free;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|S_AXIS_TVALID) begin
                    gnt_d   = pick;
                    cnt_d   = '0;
                    state_d = S_GRANT;
                end
            end
            default: begin
                if (accept) cnt_d = cnt_q + CNT_W'(1);
                // A requester dropping TVALID forfeits the rest of its burst.
                if ((accept && beat_last) || !gnt_valid) begin
                    ptr_d   = (gnt_q == CH_W'(N_CHANNELS - 1)) ? '0 : gnt_q + CH_W'(1);
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            tdata_q  <= '0;
            tdest_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (accept) begin
            tdata_q  <= S_AXIS_TDATA[gnt_q*DW +: DW];
            tdest_q  <= gnt_q;
            tlast_q  <= beat_last;
            tvalid_q <= 1'b1;
        end else if (M_AXIS_TREADY) begin
            tvalid_q <= 1'b0;
        end
    end

    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TDEST  = tdest_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TVALID = tvalid_q;

endmodule

// File: tb/tb_axis_uart_bridge_tx_arbiter.sv
// Bench for the round-robin TX arbiter: queued sources per channel, expected
// beats pushed to a scoreboard and checked by an independent output monitor.
module tb_axis_uart_bridge_tx_arbiter;
    localparam int NB  = 32;
    localparam int NCH = 4;
    localparam int MB  = 8;
    localparam int DW  = NB * 8;

    logic              aclk = 1'b0;
    logic              reset;
    logic [NCH*DW-1:0] s_tdata;
    logic [NCH-1:0]    s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]     m_tdata;
    logic [1:0]        m_tdest;
    logic              m_tlast, m_tvalid, m_tready;

    axis_uart_bridge_tx_arbiter #(.N_BYTES(NB), .N_CHANNELS(NCH), .MAX_BURST(MB)) dut (
        .aclk(aclk), .reset(reset),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
        .S_AXIS_TREADY(s_tready),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TDEST(m_tdest), .M_AXIS_TLAST(m_tlast),
        .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready)
    );

    initial forever #5 aclk = ~aclk;

    typedef struct { logic [DW-1:0] d; logic l; } beat_t;
    typedef struct { logic [DW-1:0] d; logic [1:0] dest; logic l; } exp_t;

    beat_t sq [NCH][$];
    exp_t  sb [$];
    logic [NCH-1:0] hs_in;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int hs_cyc [0:511];

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send(int ch, logic [DW-1:0] d, logic l);
        beat_t b;
        b.d = d; b.l = l;
        sq[ch].push_back(b);
    endtask

    task automatic expect_beat(logic [DW-1:0] d, int dest, logic l);
        exp_t e;
        e.d = d; e.dest = 2'(dest); e.l = l;
        sb.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            if (sq[i].size() > 0) begin
                s_tvalid[i] = 1'b1;
                s_tdata[i*DW +: DW] = sq[i][0].d;
                s_tlast[i] = sq[i][0].l;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic wait_drain(string nm, int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge aclk);
            n++;
        end
        chk(nm, sb.size(), 0);
        step();
    endtask

    task automatic wait_hs(string nm, int target, int budget);
        int n;
        n = 0;
        while (hs_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk(nm, (hs_cnt >= target), 1);
    endtask

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    // Upstream handshakes are sampled mid-cycle, queues advance just after the edge.
    initial forever begin
        @(negedge aclk);
        hs_in = s_tvalid & s_tready;
    end

    initial forever begin
        @(posedge aclk);
        #1;
        for (int i = 0; i < NCH; i++)
            if (hs_in[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        hs_in = '0;
        drive();
    end

    // Output monitor.
    initial forever begin
        exp_t e;
        @(negedge aclk);
        chk("tready_onehot", ($countones(s_tready) <= 1), 1);
        if (!reset && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got data %0h dest %0d, want no beat", m_tdata, m_tdest);
            end else begin
                e = sb.pop_front();
                chk("beat_data", m_tdata, e.d);
                chk("beat_dest", m_tdest, e.dest);
                chk("beat_last", m_tlast, e.l);
            end
            hs_cyc[hs_cnt] = cyc;
            hs_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, start, n;
        reset = 1'b1; m_tready = 1'b1;
        s_tdata = '0; s_tvalid = '0; s_tlast = '0; hs_in = '0;
        #3;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_tdest",  m_tdest, 0);
        chk("rst_tlast",  m_tlast, 0);
        chk("rst_tdata",  m_tdata, 0);
        @(posedge aclk); #3 reset = 1'b0;
        step();

        // All channels busy: 8-word bursts in order 0..3, one idle cycle per switch.
        mark = hs_cnt;
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < MB; w++) begin
                send(c, DW'(32'h100 * (c + 1) + w), 1'b0);
                expect_beat(DW'(32'h100 * (c + 1) + w), c, (w == MB - 1));
            end
        drive();
        wait_drain("rr_drain", 100);
        chk("rr_count", hs_cnt - mark, 32);
        chk("rr_span", hs_cyc[mark + 31] - hs_cyc[mark], 34);

        // Single channel 2, three words.
        mark = hs_cnt;
        send(2, DW'(8'hA1), 1'b0); send(2, DW'(8'hA2), 1'b0); send(2, DW'(8'hA3), 1'b1);
        expect_beat(DW'(8'hA1), 2, 1'b0); expect_beat(DW'(8'hA2), 2, 1'b0); expect_beat(DW'(8'hA3), 2, 1'b1);
        start = cyc;
        drive();
        n = 0;
        while (!m_tvalid && n < 10) begin
            @(negedge aclk);
            n++;
        end
        chk("ch2_latency", cyc - start, 2);
        wait_drain("ch2_drain", 20);
        chk("ch2_count", hs_cnt - mark, 3);

        // Wrap: pointer now 3, so ch3 beats ch0.
        send(0, DW'(16'hB0), 1'b0); send(0, DW'(16'hB1), 1'b1);
        send(3, DW'(16'hC0), 1'b0); send(3, DW'(16'hC1), 1'b1);
        expect_beat(DW'(16'hC0), 3, 1'b0); expect_beat(DW'(16'hC1), 3, 1'b1);
        expect_beat(DW'(16'hB0), 0, 1'b0); expect_beat(DW'(16'hB1), 0, 1'b1);
        drive();
        wait_drain("wrap_drain", 30);

        // Forfeit: ch1 stops without TLAST; pointer 2 then favours ch3 over ch0.
        send(1, DW'(16'hD0), 1'b0); send(1, DW'(16'hD1), 1'b0);
        send(3, DW'(16'hE0), 1'b0); send(3, DW'(16'hE1), 1'b1);
        send(0, DW'(16'hF0), 1'b1);
        expect_beat(DW'(16'hD0), 1, 1'b0); expect_beat(DW'(16'hD1), 1, 1'b0);
        expect_beat(DW'(16'hE0), 3, 1'b0); expect_beat(DW'(16'hE1), 3, 1'b1);
        expect_beat(DW'(16'hF0), 0, 1'b1);
        drive();
        wait_drain("forfeit_drain", 40);

        // Backpressure on the third word of a ch2 burst.
        mark = hs_cnt;
        for (int w = 0; w < 6; w++) begin
            send(2, DW'(16'h600 + w), (w == 5));
            expect_beat(DW'(16'h600 + w), 2, (w == 5));
        end
        drive();
        wait_hs("bp_start", mark + 2, 20);
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk("bp_tvalid", m_tvalid, 1);
            chk("bp_tready", s_tready, 0);
            chk("bp_tdata",  m_tdata, DW'(16'h602));
            chk("bp_tdest",  m_tdest, 2);
            chk("bp_tlast",  m_tlast, 0);
        end
        @(posedge aclk); #2 m_tready = 1'b1;
        wait_drain("bp_drain", 30);
        chk("bp_count", hs_cnt - mark, 6);

        // Reset mid-burst of ch3 (pointer 3) with ch1 also waiting.
        mark = hs_cnt;
        for (int w = 0; w < MB; w++) begin
            send(1, DW'(16'h700 + w), 1'b0);
            send(3, DW'(16'h800 + w), 1'b0);
            expect_beat(DW'(16'h800 + w), 3, (w == MB - 1));
        end
        drive();
        wait_hs("rst_start", mark + 2, 20);
        #1 reset = 1'b1;
        #1;
        chk("rstmid_tvalid", m_tvalid, 0);
        chk("rstmid_tready", s_tready, 0);
        chk("rstmid_tdest",  m_tdest, 0);
        chk("rstmid_tlast",  m_tlast, 0);
        chk("rstmid_tdata",  m_tdata, 0);
        sb.delete();
        for (int i = 0; i < NCH; i++) sq[i].delete();
        send(1, DW'(16'h900), 1'b0); send(1, DW'(16'h901), 1'b1);
        send(3, DW'(16'hA00), 1'b1);
        expect_beat(DW'(16'h900), 1, 1'b0); expect_beat(DW'(16'h901), 1, 1'b1);
        expect_beat(DW'(16'hA00), 3, 1'b1);
        drive();
        @(posedge aclk);
        @(posedge aclk); #3 reset = 1'b0;
        wait_drain("rst_drain", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
